uart_lite: RTL and testbench

- Memory-mapped 8N1 UART peripheral on the SoC local bus, in the third peripheral slot decoded alongside memory and GPIO.
- Uses the same local-bus register interface as the GPIO peripheral; address bits [31:28] are stripped upstream.
- Drives `rdata` into the processor read-data mux.
- Provides a TX FIFO, a single-entry RX holding register, a programmable baud divider and status flags for polled firmware.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/uart_lite.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_lite.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for uart_lite: register word offsets (addr[3:2]), STATUS bit positions
// and the 2-bit state encodings used by both the TX and RX machines.
package uart_pkg;

  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_RXDATA = 2'd1;
  localparam logic [1:0] UART_STATUS = 2'd2;
  localparam logic [1:0] UART_DIV    = 2'd3;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_RX_OVR    = 3;
  localparam int ST_FRAME_ERR = 4;
  localparam int ST_TX_OVF    = 5;
  localparam int ST_TX_BUSY   = 6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// DEPTH x 8 synchronous FIFO; head reads straight from the storage flops, push/pop take effect on
// the clock edge. A push while full is accepted only if a pop frees a slot in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_dat,
  input  logic       pop,
  output logic [7:0] head_dat,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/uart_lite.sv
// Polled 8N1 UART on the local bus: writes take effect on the wen edge, rdata/rvalid one cycle after ren.
// Optional UART_LOOPBACK_EN adds DIV[31]=LOOP, routing TX into RX and holding uart_tx high.
module uart_lite
  import uart_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int TX_DEPTH  = 4,
  parameter int DIV_RESET = 433
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic [3:0]  wstrb,
  output logic        wready,
  input  logic [31:0] raddr,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        uart_rx,
  output logic        uart_tx
);

  logic [1:0]       tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [DIV_W-1:0] tx_baud_q, tx_baud_d, rx_baud_q, rx_baud_d, div_q, div_d;
  logic [2:0]       tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic             txo_q, txo_d, rx_meta_q, rx_sync_q, rx_src;
  logic             rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic             frame_err_q, frame_err_d, tx_ovf_q, tx_ovf_d;
  logic [31:0]      rdata_q, rdata_d, rd_val, wmask;
  logic             rvalid_q;
  logic             tx_pop, fifo_push, fifo_full, fifo_empty, rx_new, rx_ferr, rd_clear, st_clr;
  logic [7:0]       fifo_head;
  logic             unused_ok;

  assign wready = 1'b1;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign wmask  = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign unused_ok = &{1'b0, waddr[31:4], waddr[1:0], raddr[31:4], raddr[1:0], wdata, wmask};

`ifdef UART_LOOPBACK_EN
  logic loop_q, loop_d;
  assign rx_src  = loop_q ? txo_q : uart_rx;
  assign uart_tx = loop_q ? 1'b1 : txo_q;
  always_comb begin
    loop_d = loop_q;
    if (wen && waddr[3:2] == UART_DIV && wstrb[3]) loop_d = wdata[31];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) loop_q <= 1'b0;
    else          loop_q <= loop_d;
  end
`else
  assign rx_src  = uart_rx;
  assign uart_tx = txo_q;
`endif

  uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_dat (wdata[7:0]),
    .pop      (tx_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // TX: the serial output is registered from the next-state so it lines up with the state flops.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    if (tx_state_q == S_IDLE) begin
      if (!fifo_empty) begin
        tx_pop     = 1'b1;
        tx_shift_d = fifo_head;
        tx_baud_d  = div_q;
        tx_state_d = S_START;
      end
    end else if (tx_baud_q != '0) begin
      tx_baud_d = tx_baud_q - 1'b1;
    end else begin
      tx_baud_d = div_q;
      case (tx_state_q)
        S_START: begin
          tx_state_d = S_DATA;
          tx_bit_d   = '0;
        end
        S_DATA: begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else                  tx_bit_d   = tx_bit_q + 1'b1;
        end
        default: begin
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_head;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end
      endcase
    end
    case (tx_state_d)
      S_START: txo_d = 1'b0;
      S_DATA:  txo_d = tx_shift_d[0];
      default: txo_d = 1'b1;
    endcase
  end

  // RX: half-bit delay after the start edge puts every later sample at mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_new     = 1'b0;
    rx_ferr    = 1'b0;
    if (rx_state_q == S_IDLE) begin
      if (!rx_sync_q) begin
        rx_state_d = S_START;
        rx_baud_d  = div_q >> 1;
      end
    end else if (rx_baud_q != '0) begin
      rx_baud_d = rx_baud_q - 1'b1;
    end else begin
      rx_baud_d = div_q;
      case (rx_state_q)
        S_START: begin
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
          rx_bit_d   = '0;
        end
        S_DATA: begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end
        default: begin
          rx_state_d = S_IDLE;
          rx_new     = rx_sync_q;
          rx_ferr    = !rx_sync_q;
        end
      endcase
    end
  end

  always_comb begin
    fifo_push = wen && waddr[3:2] == UART_TXDATA && wstrb[0];
    st_clr    = wen && waddr[3:2] == UART_STATUS && wstrb[0];
    rd_clear  = ren && raddr[3:2] == UART_RXDATA && rx_valid_q;
    rx_byte_d = rx_new ? rx_shift_q : rx_byte_q;
    // A byte landing on the same cycle as the read-clear is a fresh byte, not an overrun.
    rx_valid_d  = rx_new || (rx_valid_q && !rd_clear);
    rx_ovr_d    = (rx_new && rx_valid_q && !rd_clear) || (rx_ovr_q && !(st_clr && wdata[ST_RX_OVR]));
    frame_err_d = rx_ferr || (frame_err_q && !(st_clr && wdata[ST_FRAME_ERR]));
    tx_ovf_d    = (fifo_push && fifo_full && !tx_pop) || (tx_ovf_q && !(st_clr && wdata[ST_TX_OVF]));
    div_d = div_q;
    if (wen && waddr[3:2] == UART_DIV)
      div_d = (div_q & ~wmask[DIV_W-1:0]) | (wdata[DIV_W-1:0] & wmask[DIV_W-1:0]);

    rd_val = '0;
    case (raddr[3:2])
      UART_RXDATA: rd_val[8:0] = {rx_valid_q, rx_byte_q};
      UART_STATUS: begin
        rd_val[ST_TX_FULL]   = fifo_full;
        rd_val[ST_TX_EMPTY]  = fifo_empty;
        rd_val[ST_RX_VALID]  = rx_valid_q;
        rd_val[ST_RX_OVR]    = rx_ovr_q;
        rd_val[ST_FRAME_ERR] = frame_err_q;
        rd_val[ST_TX_OVF]    = tx_ovf_q;
        rd_val[ST_TX_BUSY]   = (tx_state_q != S_IDLE);
      end
      UART_DIV: begin
        rd_val[DIV_W-1:0] = div_q;
`ifdef UART_LOOPBACK_EN
        rd_val[31] = loop_q;
`endif
      end
      default: rd_val = '0;
    endcase
    rdata_d = ren ? rd_val : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q  <= S_IDLE;
      tx_baud_q   <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      txo_q       <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_baud_q   <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tx_ovf_q    <= 1'b0;
      div_q       <= DIV_W'(DIV_RESET);
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_baud_q   <= tx_baud_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txo_q       <= txo_d;
      rx_meta_q   <= rx_src;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_baud_q   <= rx_baud_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      rx_ovr_q    <= rx_ovr_d;
      frame_err_q <= frame_err_d;
      tx_ovf_q    <= tx_ovf_d;
      div_q       <= div_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= ren;
    end
  end

endmodule

// File: tb/tb_uart_lite.sv
// Bench for uart_lite: register table, hand-written TX/RX frame sequences, randomized frames
// against a serial-line model, and reset in the middle of a frame.
module tb_uart_lite;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic        wen, ren, wready, rvalid, uart_rx, uart_tx;
  logic [3:0]  wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  tx_exp_q[$];
  logic [31:0] rd, rd2;

  always #5 clk = ~clk;

  uart_lite dut (
    .clk(clk), .reset_n(reset_n),
    .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb), .wready(wready),
    .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  typedef struct {
    logic        do_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    waddr = a; wdata = d; wstrb = s; wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    raddr = a; ren = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
    check("rvalid after ren", {31'b0, rvalid}, 32'd1);
    d = rdata;
  endtask

  // Expected line: start 0, 8 data bits LSB first, stop 1, each held bitcyc cycles, frames abutted.
  task automatic check_tx_stream(input int bitcyc, input string name);
    int         waitc = 0;
    int         errs;
    int         bitn;
    logic [7:0] b;
    logic       expv;
    bit         first = 1'b1;
    do begin
      @(posedge clk); #1;
      waitc++;
    end while (uart_tx !== 1'b0 && waitc < 500);
    if (uart_tx !== 1'b0) begin
      check({name, " start timeout"}, {31'b0, uart_tx}, 32'd0);
      tx_exp_q.delete();
      return;
    end
    while (tx_exp_q.size() > 0) begin
      b    = tx_exp_q.pop_front();
      errs = 0;
      for (int k = 0; k < 10 * bitcyc; k++) begin
        if (!first) begin @(posedge clk); #1; end
        first = 1'b0;
        bitn  = k / bitcyc;
        expv  = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : b[bitn-1];
        if (uart_tx !== expv) errs++;
      end
      check($sformatf("%s frame 0x%02h bad cycles", name, b), errs, 0);
    end
    @(posedge clk); #1;
    check({name, " idle after"}, {31'b0, uart_tx}, 32'd1);
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop, input int bitcyc);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      uart_rx = frame[k];
      repeat (bitcyc) begin @(posedge clk); #1; end
    end
    uart_rx = 1'b1;
    repeat (3 * bitcyc) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m_byte, rb, tb;
    logic       m_valid, m_ferr, good;
    int         tdiv, rdiv, wc, lows;

    reset_n = 1'b0; wen = 1'b0; ren = 1'b0; uart_rx = 1'b1;
    waddr = '0; wdata = '0; wstrb = '0; raddr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset uart_tx", {31'b0, uart_tx}, 32'd1);
    check("reset wready",  {31'b0, wready},  32'd1);
    check("reset rvalid",  {31'b0, rvalid},  32'd0);
    check("reset rdata",   rdata,            32'd0);
    reset_n = 1'b1;

    vecs[0]  = '{1'b0, 32'h8, 32'h0,        4'h0, 32'h0000_0002};
    vecs[1]  = '{1'b0, 32'hC, 32'h0,        4'h0, 32'd433};
    vecs[2]  = '{1'b0, 32'h0, 32'h0,        4'h0, 32'h0};
    vecs[3]  = '{1'b1, 32'hC, 32'h0000_1234, 4'h3, 32'h0000_1234};
    vecs[4]  = '{1'b1, 32'hC, 32'hFFFF_FFFF, 4'h1, 32'h0000_12FF};
    vecs[5]  = '{1'b1, 32'hC, 32'h0000_AB00, 4'h2, 32'h0000_ABFF};
    vecs[6]  = '{1'b1, 32'hC, 32'hFFFF_FFFF, 4'h4, 32'h0000_ABFF};
    vecs[7]  = '{1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF, 32'h0000_0002};
    vecs[8]  = '{1'b1, 32'h4, 32'h0000_00FF, 4'hF, 32'h0};
    vecs[9]  = '{1'b0, 32'h8, 32'h0,        4'h0, 32'h0000_0002};
    vecs[10] = '{1'b1, 32'hC, 32'h0000_0003, 4'hF, 32'h0000_0003};
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      bus_read(vecs[i].addr, rd);
      check($sformatf("table[%0d] addr 0x%0h", i, vecs[i].addr), rd, vecs[i].exp);
    end

    // Single frame, DIV=3: 40 cycles of exact waveform, then idle.
    tx_exp_q.push_back(8'h55);
    fork
      bus_write(32'h0, 32'h55, 4'h1);
      check_tx_stream(4, "tx 0x55");
    join
    bus_read(32'h8, rd);
    check("status after tx 0x55", rd, 32'h0000_0002);

    // Five back-to-back bytes fit (first already popped); sixth overflows.
    for (int i = 1; i <= 5; i++) tx_exp_q.push_back(8'(i));
    fork
      begin
        for (int i = 1; i <= 6; i++) bus_write(32'h0, i, 4'h1);
        bus_read(32'h8, rd2);
        check("status while full", rd2, 32'h0000_0061);
      end
      check_tx_stream(4, "burst");
    join
    bus_read(32'h8, rd);
    check("status after burst", rd, 32'h0000_0022);
    bus_write(32'h8, 32'h20, 4'h1);
    bus_read(32'h8, rd);
    check("tx_ovf cleared", rd, 32'h0000_0002);

    // RX: clean byte, read-clear, overrun, framing error, W1C.
    send_serial(8'hA3, 1'b1, 4);
    bus_read(32'h8, rd);  check("rx status A3", rd, 32'h0000_0006);
    bus_read(32'h4, rd);  check("rxdata A3", rd, 32'h0000_01A3);
    bus_read(32'h4, rd);  check("rxdata A3 again", rd, 32'h0000_00A3);
    send_serial(8'h11, 1'b1, 4);
    send_serial(8'h22, 1'b1, 4);
    bus_read(32'h8, rd);  check("rx status overrun", rd, 32'h0000_000E);
    send_serial(8'h5A, 1'b0, 4);
    bus_read(32'h8, rd);  check("rx status frame err", rd, 32'h0000_001E);
    bus_read(32'h4, rd);  check("rxdata after ovr", rd, 32'h0000_0122);
    bus_write(32'h8, 32'h38, 4'h1);
    bus_read(32'h8, rd);  check("status w1c", rd, 32'h0000_0002);

    // Randomized frames against the line model.
    m_byte = 8'h22; m_valid = 1'b0; m_ferr = 1'b0;
    for (int it = 0; it < 8; it++) begin
      tdiv = $urandom_range(0, 6);
      tb   = 8'($urandom);
      bus_write(32'hC, tdiv, 4'hF);
      tx_exp_q.push_back(tb);
      fork
        bus_write(32'h0, {24'b0, tb}, 4'h1);
        check_tx_stream(tdiv + 1, $sformatf("rand tx div%0d", tdiv));
      join
      rdiv = $urandom_range(3, 7);
      rb   = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      bus_write(32'hC, rdiv, 4'hF);
      send_serial(rb, good, rdiv + 1);
      if (good) begin m_valid = 1'b1; m_byte = rb; end
      else m_ferr = 1'b1;
      bus_read(32'h8, rd);
      check($sformatf("rand rx status div%0d", rdiv), rd,
            32'h2 | ({31'b0, m_valid} << 2) | ({31'b0, m_ferr} << 4));
      bus_read(32'h4, rd);
      check($sformatf("rand rxdata div%0d", rdiv), rd, {23'b0, m_valid, m_byte});
      m_valid = 1'b0;
      bus_write(32'h8, 32'h10, 4'h1);
      m_ferr = 1'b0;
    end

    // Reset in the middle of a frame with a second byte still queued.
    bus_write(32'hC, 32'h3, 4'hF);
    bus_write(32'h0, 32'h5A, 4'h1);
    bus_write(32'h0, 32'hA5, 4'h1);
    wc = 0;
    while (uart_tx !== 1'b0 && wc < 200) begin @(posedge clk); #1; wc++; end
    check("midframe start seen", {31'b0, uart_tx}, 32'd0);
    repeat (6) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("uart_tx during reset", {31'b0, uart_tx}, 32'd1);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1) lows++;
    end
    check("uart_tx idle after reset", lows, 0);
    bus_read(32'h8, rd);  check("status after reset", rd, 32'h0000_0002);
    bus_read(32'hC, rd);  check("div after reset", rd, 32'd433);

`ifdef UART_LOOPBACK_EN
    bus_write(32'hC, 32'h8000_0003, 4'hF);
    bus_read(32'hC, rd);  check("div with loop", rd, 32'h8000_0003);
    bus_write(32'h0, 32'hC6, 4'h1);
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1) lows++;
    end
    check("uart_tx held in loopback", lows, 0);
    bus_read(32'h4, rd);  check("loopback rxdata", rd, 32'h0000_01C6);
`else
    bus_write(32'hC, 32'h8000_0003, 4'hF);
    bus_read(32'hC, rd);  check("div bit31 ignored", rd, 32'h0000_0003);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
